fg_burst_gen: RTL

//  Flow generator burst scheduler; sits directly downstream of the flow descriptor FIFO.

---
 rtl/fg_burst_gen_if.sv | 45 ++++
 rtl/fg_burst_gen.sv | 97 +++++++++
 2 files changed

// File: rtl/fg_burst_gen_if.sv
// fg_burst_gen_if: flow descriptor input channel and burst descriptor output channel
interface fg_burst_gen_if #(
  parameter int DEST_WIDTH = 8
);
  logic                  input_fd_valid;
  logic                  input_fd_ready;
  logic [DEST_WIDTH-1:0] input_fd_dest;
  logic [15:0]           input_fd_rate_num;
  logic [15:0]           input_fd_rate_denom;
  logic [31:0]           input_fd_len;
  logic [31:0]           input_fd_burst_len;
  logic                  output_bd_valid;
  logic                  output_bd_ready;
  logic [DEST_WIDTH-1:0] output_bd_dest;
  logic [31:0]           output_bd_len;
  logic                  output_bd_last;
  modport master (
    output input_fd_valid,
    input  input_fd_ready,
    output input_fd_dest,
    output input_fd_rate_num,
    output input_fd_rate_denom,
    output input_fd_len,
    output input_fd_burst_len,
    input  output_bd_valid,
    output output_bd_ready,
    input  output_bd_dest,
    input  output_bd_len,
    input  output_bd_last
  );
  modport slave (
    input  input_fd_valid,
    output input_fd_ready,
    input  input_fd_dest,
    input  input_fd_rate_num,
    input  input_fd_rate_denom,
    input  input_fd_len,
    input  input_fd_burst_len,
    output output_bd_valid,
    input  output_bd_ready,
    output output_bd_dest,
    output output_bd_len,
    output output_bd_last
  );
endinterface

// File: rtl/fg_burst_gen.sv
// fg_burst_gen: splits flow descriptors into rate-paced burst descriptors
module fg_burst_gen #(
  parameter int DEST_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  fg_burst_gen_if.slave  bif,
  output logic           busy
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [15:0]           r_num;
  logic [15:0]           r_denom;
  logic [31:0]           r_burst_len;
  logic [31:0]           r_remaining;
  logic signed [49:0]    r_credit;
  logic                  r_bd_valid;
  logic [DEST_WIDTH-1:0] r_bd_dest;
  logic [31:0]           r_bd_len;
  logic                  r_bd_last;
  logic                  w_accept;
  logic                  w_unthrottled;
  logic                  w_credit_ok;
  logic                  w_out_free;
  logic                  w_issue;
  logic [31:0]           w_chunk;
  logic                  w_last;
  logic [47:0]           w_prod;
  assign w_accept      = (r_state == IDLE) & bif.input_fd_valid;
  assign w_unthrottled = (r_num == 16'd0) | (r_denom == 16'd0);
  assign w_credit_ok   = ~r_credit[49];
  assign w_out_free    = ~r_bd_valid | bif.output_bd_ready;
  assign w_issue       = (r_state == ISSUE) & (w_unthrottled | w_credit_ok) & w_out_free;
  assign w_chunk       = ((r_burst_len == 32'd0) | (r_remaining <= r_burst_len)) ? r_remaining : r_burst_len;
  assign w_last        = (w_chunk == r_remaining);
  assign w_prod        = {16'd0, w_chunk} * {32'd0, r_denom};
  assign bif.input_fd_ready  = (r_state == IDLE);
  assign bif.output_bd_valid = r_bd_valid;
  assign bif.output_bd_dest  = r_bd_dest;
  assign bif.output_bd_len   = r_bd_len;
  assign bif.output_bd_last  = r_bd_last;
  assign busy = (r_state != IDLE) | r_bd_valid;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end
  // next state: zero-length flows are swallowed without leaving IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE)
      w_state_nxt = (w_accept && bif.input_fd_len != 32'd0) ? ISSUE : IDLE;
    else
      w_state_nxt = (w_issue && w_last) ? IDLE : ISSUE;
  end
  // flow context and credit: credit only climbs while negative, so it saturates at the issue threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest      <= '0;
      r_num       <= '0;
      r_denom     <= '0;
      r_burst_len <= '0;
      r_remaining <= '0;
      r_credit    <= '0;
    end else if (w_accept) begin
      r_dest      <= bif.input_fd_dest;
      r_num       <= bif.input_fd_rate_num;
      r_denom     <= bif.input_fd_rate_denom;
      r_burst_len <= bif.input_fd_burst_len;
      r_remaining <= bif.input_fd_len;
      r_credit    <= '0;
    end else if (w_issue) begin
      r_remaining <= r_remaining - w_chunk;
      if (!w_unthrottled) r_credit <= r_credit - $signed({2'b00, w_prod});
    end else if (r_state == ISSUE && !w_unthrottled && !w_credit_ok) begin
      r_credit <= r_credit + $signed({34'd0, r_num});
    end
  end
  // output register: holds the burst until consumed, reloads in the same cycle for back-to-back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bd_valid <= 1'b0;
      r_bd_dest  <= '0;
      r_bd_len   <= '0;
      r_bd_last  <= 1'b0;
    end else if (w_issue) begin
      r_bd_valid <= 1'b1;
      r_bd_dest  <= r_dest;
      r_bd_len   <= w_chunk;
      r_bd_last  <= w_last;
    end else if (bif.output_bd_ready) begin
      r_bd_valid <= 1'b0;
    end
  end
endmodule
